// File: rtl/xform_pkg.sv
// Shared types and constants for the transform-quantise datapath scheduler.
package xform_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      XFER    = 2'd1,
      WAIT_FB = 2'd2,
      MBDONE  = 2'd3
   } sched_state_t;

   localparam logic PH_LUMA   = 1'b0;
   localparam logic PH_CHROMA = 1'b1;

   localparam int XF_BEATS        = 4;
   localparam int DEF_LUMA_BLKS   = 16;
   localparam int DEF_CHROMA_BLKS = 8;
   localparam int DEF_FB_TIMEOUT  = 64;

endpackage

// File: rtl/fb_timer.sv
// Feedback timeout counter: counts enabled cycles since the last clear and flags
// the cycle whose increment reaches the programmed limit (a limit of 0 never expires).
module fb_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] limit,
   output logic         expire
);

   localparam logic [W-1:0] ZERO = {W{1'b0}};
   localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};

   logic [W-1:0] count_r;

   // Cycle counter; clear wins over enable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= ZERO;
      end else if (clr) begin
         count_r <= ZERO;
      end else if (en) begin
         count_r <= count_r + ONE;
      end else begin
         count_r <= count_r;
      end
   end

   assign expire = (limit != ZERO) && (count_r == (limit - ONE));

endmodule

// File: rtl/xform_sched.sv
// Grants the shared transform datapath to luma then chroma 4x4 blocks in
// macroblock order, one block transfer per grant, paced by reconstruction feedback.
module xform_sched #(
   parameter int LUMA_BLKS   = xform_pkg::DEF_LUMA_BLKS,
   parameter int CHROMA_BLKS = xform_pkg::DEF_CHROMA_BLKS,
   parameter int BEATS       = xform_pkg::XF_BEATS,
   parameter int FB_TIMEOUT  = xform_pkg::DEF_FB_TIMEOUT
) (
   input  logic       CLK2,
   input  logic       RESET_N,
   input  logic       NEWLINE,
   input  logic       REQ_L,
   input  logic       REQ_C,
   input  logic       VALIDI,
   input  logic       READYO,
   input  logic       FBSTROBE,
   output logic       GNT_L,
   output logic       GNT_C,
   output logic       READYI,
   output logic       SEL,
   output logic       CRCB,
   output logic [3:0] BLKIDX,
   output logic       MBDONE,
   output logic       BUSY,
   output logic       ERR
);

   import xform_pkg::*;

   localparam logic [4:0] LUMA_END   = 5'(LUMA_BLKS);
   localparam logic [3:0] CHROMA_END = 4'(CHROMA_BLKS);
   localparam logic [3:0] CR_START   = 4'(CHROMA_BLKS / 2);
   localparam logic [1:0] LAST_BEAT  = 2'(BEATS - 1);
   localparam logic [7:0] TMO_LIMIT  = 8'(FB_TIMEOUT);

   sched_state_t state_r, state_s;
   logic [4:0]   luma_cnt_r, luma_cnt_s;
   logic [3:0]   chroma_cnt_r, chroma_cnt_s;
   logic [1:0]   beat_cnt_r, beat_cnt_s;
   logic         gnt_l_r, gnt_l_s, gnt_c_r, gnt_c_s;
   logic         err_r, err_s;
   logic         sel_r, crcb_r, mbdone_r, busy_r;
   logic [3:0]   blkidx_r;
   logic         phase_s, phase_nxt_s, fb_adv_s;
   logic         tmr_clr_s, tmr_en_s, tmr_expire_s;

   assign phase_s     = (luma_cnt_r >= LUMA_END) ? PH_CHROMA : PH_LUMA;
   assign phase_nxt_s = (luma_cnt_s >= LUMA_END) ? PH_CHROMA : PH_LUMA;
   assign tmr_en_s    = (state_r == WAIT_FB);

   fb_timer #(.W(8)) u_fb_timer (
      .clk    (CLK2),
      .rst_n  (RESET_N),
      .clr    (tmr_clr_s),
      .en     (tmr_en_s),
      .limit  (TMO_LIMIT),
      .expire (tmr_expire_s)
   );

   // Next-state, counters, grants and error flag; NEWLINE overrides everything.
   always_comb begin
      state_s      = state_r;
      luma_cnt_s   = luma_cnt_r;
      chroma_cnt_s = chroma_cnt_r;
      beat_cnt_s   = beat_cnt_r;
      gnt_l_s      = 1'b0;
      gnt_c_s      = 1'b0;
      err_s        = err_r;
      tmr_clr_s    = 1'b1;
      fb_adv_s     = 1'b0;
      if (NEWLINE) begin
         state_s      = IDLE;
         luma_cnt_s   = 5'd0;
         chroma_cnt_s = 4'd0;
         beat_cnt_s   = 2'd0;
      end else begin
         case (state_r)
            IDLE: begin
               beat_cnt_s = 2'd0;
               if ((phase_s == PH_LUMA) && REQ_L) begin
                  state_s = XFER;
                  gnt_l_s = 1'b1;
               end else if ((phase_s == PH_CHROMA) && REQ_C) begin
                  state_s = XFER;
                  gnt_c_s = 1'b1;
               end else begin
                  state_s = IDLE;
               end
            end
            XFER: begin
               gnt_l_s = gnt_l_r;
               gnt_c_s = gnt_c_r;
               if (VALIDI && READYO) begin
                  if (beat_cnt_r == LAST_BEAT) begin
                     beat_cnt_s = 2'd0;
                     gnt_l_s    = 1'b0;
                     gnt_c_s    = 1'b0;
                     state_s    = WAIT_FB;
                  end else begin
                     beat_cnt_s = beat_cnt_r + 2'd1;
                  end
               end else begin
                  beat_cnt_s = beat_cnt_r;
               end
            end
            WAIT_FB: begin
               // A strobe coinciding with expiry counts as genuine feedback.
               fb_adv_s  = FBSTROBE | tmr_expire_s;
               tmr_clr_s = fb_adv_s;
               if (fb_adv_s) begin
                  if (!FBSTROBE) begin
                     err_s = 1'b1;
                  end else begin
                     err_s = err_r;
                  end
                  if (phase_s == PH_LUMA) begin
                     luma_cnt_s = luma_cnt_r + 5'd1;
                     state_s    = IDLE;
                  end else begin
                     chroma_cnt_s = chroma_cnt_r + 4'd1;
                     if (chroma_cnt_s == CHROMA_END) begin
                        state_s = xform_pkg::MBDONE;
                     end else begin
                        state_s = IDLE;
                     end
                  end
               end else begin
                  state_s = WAIT_FB;
               end
            end
            xform_pkg::MBDONE: begin
               luma_cnt_s   = 5'd0;
               chroma_cnt_s = 4'd0;
               state_s      = IDLE;
            end
            default: begin
               state_s      = IDLE;
               luma_cnt_s   = 5'd0;
               chroma_cnt_s = 4'd0;
               beat_cnt_s   = 2'd0;
            end
         endcase
      end
   end

   // State, counters and registered output decode.
   always_ff @(posedge CLK2 or negedge RESET_N) begin
      if (!RESET_N) begin
         state_r      <= IDLE;
         luma_cnt_r   <= 5'd0;
         chroma_cnt_r <= 4'd0;
         beat_cnt_r   <= 2'd0;
         gnt_l_r      <= 1'b0;
         gnt_c_r      <= 1'b0;
         err_r        <= 1'b0;
         sel_r        <= 1'b0;
         crcb_r       <= 1'b0;
         blkidx_r     <= 4'd0;
         mbdone_r     <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         state_r      <= state_s;
         luma_cnt_r   <= luma_cnt_s;
         chroma_cnt_r <= chroma_cnt_s;
         beat_cnt_r   <= beat_cnt_s;
         gnt_l_r      <= gnt_l_s;
         gnt_c_r      <= gnt_c_s;
         err_r        <= err_s;
         sel_r        <= phase_nxt_s;
         crcb_r       <= (chroma_cnt_s >= CR_START);
         blkidx_r     <= (phase_nxt_s == PH_CHROMA) ? chroma_cnt_s : luma_cnt_s[3:0];
         mbdone_r     <= (state_s == xform_pkg::MBDONE);
         busy_r       <= (state_s != IDLE);
      end
   end

   assign GNT_L  = gnt_l_r;
   assign GNT_C  = gnt_c_r;
   assign READYI = READYO & (gnt_l_r | gnt_c_r);
   assign SEL    = sel_r;
   assign CRCB   = crcb_r;
   assign BLKIDX = blkidx_r;
   assign MBDONE = mbdone_r;
   assign BUSY   = busy_r;
   assign ERR    = err_r;

endmodule

// File: tb/tb_xform_sched.sv
// Self-checking bench for xform_sched: vector table, directed corner sequences
// and randomized traffic against a block-position reference model.
module tb_xform_sched;

   localparam int NL    = 16;
   localparam int NC    = 8;
   localparam int NBEAT = 4;
   localparam int TMO   = 64;

   // stimulus order {NEWLINE, REQ_L, REQ_C, VALIDI, READYO, FBSTROBE}
   localparam logic [5:0] I_NONE = 6'b000000;
   localparam logic [5:0] I_NL   = 6'b100000;
   localparam logic [5:0] I_REQ  = 6'b011010;
   localparam logic [5:0] I_BEAT = 6'b011110;
   localparam logic [5:0] I_FB   = 6'b011011;

   logic CLK2 = 1'b0, RESET_N = 1'b0, NEWLINE = 1'b0, REQ_L = 1'b0, REQ_C = 1'b0;
   logic VALIDI = 1'b0, READYO = 1'b0, FBSTROBE = 1'b0;
   logic GNT_L, GNT_C, READYI, SEL, CRCB, MBDONE, BUSY, ERR;
   logic [3:0] BLKIDX;

   int n_cmp = 0, n_bad = 0, mb_seen = 0, n_lblk = 0, n_cblk = 0;

   // reference model: linear block position 0..NL+NC within the macroblock
   int m_blk, m_beats, m_wcnt;
   bit m_gnt, m_wait, m_done, m_err;

   typedef struct packed {
      logic [5:0] stim;
      logic [7:0] expo;   // {GNT_L, GNT_C, READYI, BUSY, BLKIDX}
   } vec_t;
   vec_t tbl[16];

   always #5 CLK2 = ~CLK2;

   xform_sched #(.LUMA_BLKS(NL), .CHROMA_BLKS(NC), .BEATS(NBEAT), .FB_TIMEOUT(TMO)) dut (
      .CLK2(CLK2), .RESET_N(RESET_N), .NEWLINE(NEWLINE), .REQ_L(REQ_L), .REQ_C(REQ_C),
      .VALIDI(VALIDI), .READYO(READYO), .FBSTROBE(FBSTROBE), .GNT_L(GNT_L), .GNT_C(GNT_C),
      .READYI(READYI), .SEL(SEL), .CRCB(CRCB), .BLKIDX(BLKIDX), .MBDONE(MBDONE),
      .BUSY(BUSY), .ERR(ERR)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_blk = 0; m_beats = 0; m_wcnt = 0;
      m_gnt = 1'b0; m_wait = 1'b0; m_done = 1'b0; m_err = 1'b0;
   endfunction

   function automatic void model_step(input logic [5:0] s);
      if (s[5]) begin
         m_blk = 0; m_gnt = 1'b0; m_beats = 0; m_wait = 1'b0; m_wcnt = 0; m_done = 1'b0;
      end else if (m_done) begin
         m_done = 1'b0;
         m_blk  = 0;
      end else if (m_wait) begin
         if (s[0] || (TMO != 0 && m_wcnt + 1 == TMO)) begin
            if (!s[0]) m_err = 1'b1;
            m_wait = 1'b0;
            m_wcnt = 0;
            m_blk++;
            if (m_blk == NL + NC) m_done = 1'b1;
         end else begin
            m_wcnt++;
         end
      end else if (m_gnt) begin
         if (s[2] && s[1]) begin
            m_beats++;
            if (m_beats == NBEAT) begin
               m_gnt = 1'b0; m_beats = 0; m_wait = 1'b1;
            end
         end
      end else if ((m_blk >= NL) ? s[3] : s[4]) begin
         m_gnt = 1'b1;
      end
   endfunction

   function automatic logic [11:0] exp_vec(input logic ro);
      logic [3:0] idx = 4'((m_blk < NL) ? m_blk : m_blk - NL);
      return {m_gnt && (m_blk < NL), m_gnt && (m_blk >= NL), m_gnt && ro, m_blk >= NL,
              m_blk >= NL + NC / 2, idx, m_done, m_gnt || m_wait || m_done, m_err};
   endfunction

   function automatic logic [11:0] dut_vec();
      return {GNT_L, GNT_C, READYI, SEL, CRCB, BLKIDX, MBDONE, BUSY, ERR};
   endfunction

   task automatic step(input logic [5:0] s);
      {NEWLINE, REQ_L, REQ_C, VALIDI, READYO, FBSTROBE} = s;
      @(posedge CLK2);
      #1;
      model_step(s);
      check("model", dut_vec(), exp_vec(s[1]));
      if (MBDONE === 1'b1) mb_seen++;
   endtask

   task automatic blk(input int b, input int waits);
      step(I_REQ);
      if (GNT_L === 1'b1) n_lblk++;
      if (GNT_C === 1'b1) n_cblk++;
      check("blk_grant", {GNT_L, GNT_C}, (b < NL) ? 2'b10 : 2'b01);
      check("blk_index", {CRCB, SEL, BLKIDX},
            {b >= NL + NC / 2, b >= NL, 4'((b < NL) ? b : b - NL)});
      repeat (NBEAT) step(I_BEAT);
      check("blk_drop", {GNT_L, GNT_C, BUSY}, 3'b001);
      repeat (waits) step(I_REQ);
      step(I_FB);
   endtask

   initial begin
      logic [5:0] bp_pat = 6'b111001;
      logic       g;
      int         gcyc, nbeat, wc;

      tbl[0]  = '{6'b001000, 8'b0000_0000};
      tbl[1]  = '{6'b011000, 8'b1001_0000};
      tbl[2]  = '{6'b011110, 8'b1011_0000};
      tbl[3]  = '{6'b000100, 8'b1001_0000};
      tbl[4]  = '{6'b000110, 8'b1011_0000};
      tbl[5]  = '{6'b000010, 8'b1011_0000};
      tbl[6]  = '{6'b000110, 8'b1011_0000};
      tbl[7]  = '{6'b000110, 8'b0001_0000};
      tbl[8]  = '{6'b000000, 8'b0001_0000};
      tbl[9]  = '{6'b000001, 8'b0000_0001};
      tbl[10] = '{6'b000001, 8'b0000_0001};
      tbl[11] = '{6'b010000, 8'b1001_0001};
      tbl[12] = '{6'b000011, 8'b1011_0001};
      tbl[13] = '{6'b110110, 8'b0000_0000};
      tbl[14] = '{6'b010000, 8'b1001_0000};
      tbl[15] = '{6'b100000, 8'b0000_0000};

      model_reset();
      repeat (2) @(posedge CLK2);
      #1;
      check("reset_state", dut_vec(), 12'h000);
      RESET_N = 1'b1;

      for (int i = 0; i < 16; i++) begin
         step(tbl[i].stim);
         check($sformatf("vec%0d", i), {GNT_L, GNT_C, READYI, BUSY, BLKIDX}, tbl[i].expo);
      end

      // full macroblock in order, feedback three cycles after each grant drop
      step(I_NL);
      mb_seen = 0; n_lblk = 0; n_cblk = 0;
      for (int b = 0; b < NL + NC; b++) blk(b, 2);
      check("mb_pulse", MBDONE, 1);
      step(I_NONE);
      check("mb_after", {MBDONE, SEL, BLKIDX}, 6'b0);
      check("mb_count", mb_seen, 1);
      check("luma_blocks", n_lblk, NL);
      check("chroma_blocks", n_cblk, NC);

      // backpressure on beats 1 and 2
      step(I_NL);
      step(6'b010010);
      gcyc = (GNT_L === 1'b1) ? 1 : 0;
      nbeat = 0;
      for (int k = 0; k < 6; k++) begin
         g = GNT_L;
         step({3'b000, 1'b1, bp_pat[k], 1'b0});
         if (g === 1'b1 && bp_pat[k]) nbeat++;
         if (GNT_L === 1'b1) gcyc++;
      end
      check("bp_grant_cycles", gcyc, 6);
      check("bp_beats", nbeat, NBEAT);
      step(6'b000010);
      check("bp_readyi_wait", {READYI, BUSY}, 2'b01);
      step(I_FB);

      // off-phase chroma request at macroblock start
      step(I_NL);
      for (int k = 0; k < 5; k++) begin
         step(6'b001000);
         check("offphase_idle", {GNT_L, GNT_C, BUSY}, 3'b000);
      end
      step(6'b011000);
      check("offphase_luma", {GNT_L, GNT_C}, 2'b10);
      repeat (NBEAT) step(I_BEAT);
      step(I_FB);

      // strobe on the expiry cycle, then a real timeout on block 5
      step(I_NL);
      for (int b = 0; b < 3; b++) blk(b, 2);
      blk(3, TMO - 1);
      check("tmo_tie", {ERR, BLKIDX}, {1'b0, 4'd4});
      blk(4, 2);
      step(I_REQ);
      repeat (NBEAT) step(I_BEAT);
      wc = 0;
      while (ERR !== 1'b1 && wc < 200) begin
         step(I_REQ);
         wc++;
      end
      check("tmo_cycles", wc, TMO);
      check("tmo_index", {ERR, BLKIDX}, {1'b1, 4'd6});
      for (int b = 6; b < NL + NC; b++) blk(b, 0);
      check("err_sticky_mb", {MBDONE, ERR}, 2'b11);

      // NEWLINE mid-transfer on chroma block 2
      step(I_NL);
      for (int b = 0; b < NL + 2; b++) blk(b, 0);
      step(I_REQ);
      check("nl_pre", {GNT_C, BLKIDX}, {1'b1, 4'd2});
      step(I_BEAT);
      step(6'b110110);
      check("nl_xfer", {GNT_L, GNT_C, BUSY, MBDONE, SEL, BLKIDX, ERR}, {5'b00000, 4'd0, 1'b1});
      step(I_REQ);
      check("nl_next_luma", {GNT_L, GNT_C}, 2'b10);
      repeat (NBEAT) step(I_BEAT);
      check("nl_wait", BUSY, 1);

      // asynchronous reset while waiting for feedback
      #2 RESET_N = 1'b0;
      #1 check("async_reset", {dut_vec(), READYO}, {12'h000, 1'b1});
      model_reset();
      #2 RESET_N = 1'b1;
      step(I_REQ);
      check("post_reset_luma", {GNT_L, GNT_C}, 2'b10);

      // randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         logic [5:0] vin;
         vin[5] = ($urandom_range(999) == 0);
         vin[4] = ($urandom_range(9) < 7);
         vin[3] = ($urandom_range(9) < 7);
         vin[2] = ($urandom_range(9) < 7);
         vin[1] = ($urandom_range(9) < 7);
         vin[0] = ($urandom_range(99) < 12);
         step(vin);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
